// File: rtl/controlador_compuerta_pkg.sv
// Shared types and defaults for the parking-gate access controller.
// Holds the state encoding and the default PIN codes.
package compuerta_pkg;

    typedef enum logic [2:0] {
        ESPERA     = 3'd0,
        ESPERA_PIN = 3'd1,
        ABIERTO    = 3'd2,
        ALARMA     = 3'd3,
        BLOQUEO    = 3'd4
    } estado_t;

    localparam logic [7:0] PIN_CORRECTO_DEF = 8'b0000_1000;
    localparam logic [7:0] PIN_ESPERA_DEF   = 8'b0000_0000;
    localparam int         MAX_INTENTOS_DEF = 3;

endpackage

// File: rtl/controlador_compuerta_if.sv
// Gate sensor/keypad/indicator bundle.
// The master side drives the sensors and the keypad; the slave side is the controller.
interface controlador_compuerta_if;

    logic       Vehiculo;
    logic       Termino;
    logic [7:0] Pin;
    logic       Cerrado;
    logic       Abierto;
    logic       Alarma;
    logic       Bloqueo;

    modport master (
        output Vehiculo, Termino, Pin,
        input  Cerrado, Abierto, Alarma, Bloqueo
    );

    modport slave (
        input  Vehiculo, Termino, Pin,
        output Cerrado, Abierto, Alarma, Bloqueo
    );

endinterface

// File: rtl/controlador_compuerta_detector_pin.sv
// Keypad entry detector: registers the previous Pin value and flags a fresh entry
// as correct or wrong. A code held for several cycles produces a single event.
import compuerta_pkg::*;

module detector_pin #(
    parameter logic [7:0] PIN_CORRECTO = PIN_CORRECTO_DEF,
    parameter logic [7:0] PIN_ESPERA   = PIN_ESPERA_DEF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [7:0] i_pin,
    output logic       o_pin_ok,
    output logic       o_pin_mal
);

    logic [7:0] r_pin_prev;
    logic       w_evento;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_pin_prev <= PIN_ESPERA;
        end else begin
            r_pin_prev <= i_pin;
        end
    end

    assign w_evento  = (i_pin != PIN_ESPERA) && (r_pin_prev == PIN_ESPERA);
    assign o_pin_ok  = w_evento && (i_pin == PIN_CORRECTO);
    assign o_pin_mal = w_evento && (i_pin != PIN_CORRECTO);

endmodule

// File: rtl/controlador_compuerta.sv
// Parking-gate controller: vehicle detection, PIN entry, wrong-attempt alarm
// and tailgating lock. Outputs are a Moore decode of the state register.
import compuerta_pkg::*;

module controlador_compuerta #(
    parameter logic [7:0] PIN_CORRECTO = PIN_CORRECTO_DEF,
    parameter logic [7:0] PIN_ESPERA   = PIN_ESPERA_DEF,
    parameter int         MAX_INTENTOS = MAX_INTENTOS_DEF
) (
    input  logic                    Clk,
    input  logic                    Reset,
    controlador_compuerta_if.slave  bus
);

    localparam logic [1:0] LIM = 2'(MAX_INTENTOS);

    estado_t    r_state;
    estado_t    w_state_nxt;
    logic [1:0] r_intentos;
    logic [1:0] w_intentos_nxt;
    logic [1:0] w_intentos_inc;
    logic       w_pin_ok;
    logic       w_pin_mal;

    detector_pin #(
        .PIN_CORRECTO (PIN_CORRECTO),
        .PIN_ESPERA   (PIN_ESPERA)
    ) u_detector (
        .Clk       (Clk),
        .Reset     (Reset),
        .i_pin     (bus.Pin),
        .o_pin_ok  (w_pin_ok),
        .o_pin_mal (w_pin_mal)
    );

    // Counter saturates at the limit so repeated wrong codes in ALARMA never wrap.
    assign w_intentos_inc = (r_intentos >= LIM) ? r_intentos : r_intentos + 2'd1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= ESPERA;
            r_intentos <= 2'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_intentos <= w_intentos_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_intentos_nxt = r_intentos;
        unique case (r_state)
            ESPERA: begin
                if (bus.Vehiculo) begin
                    w_state_nxt    = ESPERA_PIN;
                    w_intentos_nxt = 2'd0;
                end
            end
            ESPERA_PIN: begin
                if (w_pin_ok) begin
                    w_state_nxt    = ABIERTO;
                    w_intentos_nxt = 2'd0;
                end else if (w_pin_mal) begin
                    w_intentos_nxt = w_intentos_inc;
                    if (w_intentos_inc == LIM) begin
                        w_state_nxt = ALARMA;
                    end
                end else if (!bus.Vehiculo) begin
                    w_state_nxt    = ESPERA;
                    w_intentos_nxt = 2'd0;
                end
            end
            ALARMA: begin
                if (w_pin_ok) begin
                    w_state_nxt    = ABIERTO;
                    w_intentos_nxt = 2'd0;
                end else if (w_pin_mal) begin
                    w_intentos_nxt = w_intentos_inc;
                end
            end
            ABIERTO: begin
                if (bus.Termino) begin
                    w_state_nxt = bus.Vehiculo ? BLOQUEO : ESPERA;
                end
            end
            BLOQUEO: begin
                if (w_pin_ok) begin
                    w_state_nxt    = ESPERA;
                    w_intentos_nxt = 2'd0;
                end
            end
            default: begin
                w_state_nxt    = ESPERA;
                w_intentos_nxt = 2'd0;
            end
        endcase
    end

    always_comb begin
        bus.Cerrado = 1'b1;
        bus.Abierto = 1'b0;
        bus.Alarma  = 1'b0;
        bus.Bloqueo = 1'b0;
        unique case (r_state)
            ABIERTO: begin
                bus.Cerrado = 1'b0;
                bus.Abierto = 1'b1;
            end
            ALARMA: begin
                bus.Alarma = 1'b1;
            end
            BLOQUEO: begin
                bus.Alarma  = 1'b1;
                bus.Bloqueo = 1'b1;
            end
            default: begin
                bus.Cerrado = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_controlador_compuerta.sv
// Directed bench for the parking-gate controller.
// Outputs are packed as {Cerrado, Abierto, Alarma, Bloqueo}.
module tb_controlador_compuerta;

    localparam logic [3:0] CER = 4'b1000;
    localparam logic [3:0] ABR = 4'b0100;
    localparam logic [3:0] ALR = 4'b1010;
    localparam logic [3:0] BLQ = 4'b1011;

    logic Clk;
    logic Reset;
    int   checks;
    int   errors;

    controlador_compuerta_if bus ();

    controlador_compuerta dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %b want %b", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] outs();
        return {bus.Cerrado, bus.Abierto, bus.Alarma, bus.Bloqueo};
    endfunction

    // Advance one edge, then verify the gate invariants on the settled outputs.
    task automatic tick();
        @(posedge Clk);
        #1;
        chk("inv", {2'b00, bus.Cerrado ^ bus.Abierto, bus.Bloqueo & ~bus.Alarma}, 4'b0010);
    endtask

    task automatic entry(input logic [7:0] code);
        bus.Pin = code;
        tick();
        bus.Pin = 8'h00;
        tick();
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        Reset        = 1'b1;
        bus.Vehiculo = 1'b0;
        bus.Termino  = 1'b0;
        bus.Pin      = 8'h00;
        tick();
        Reset = 1'b0;
        chk("reset", outs(), CER);

        // One wrong entry, then two more reach the alarm.
        bus.Vehiculo = 1'b1;
        tick();
        chk("esp_pin", outs(), CER);
        entry(8'hFF);
        chk("wrong1", outs(), CER);
        entry(8'hFF);
        chk("wrong2", outs(), CER);
        bus.Pin = 8'hFF;
        tick();
        chk("wrong3", outs(), ALR);
        bus.Pin = 8'h00;
        tick();
        entry(8'h55);
        chk("alr_sat", outs(), ALR);
        bus.Pin = 8'h08;
        tick();
        chk("alr_ok", outs(), ABR);
        bus.Pin      = 8'h00;
        bus.Vehiculo = 1'b0;
        bus.Termino  = 1'b1;
        tick();
        chk("pass1", outs(), CER);
        bus.Termino = 1'b0;

        // Correct code held for several cycles.
        bus.Vehiculo = 1'b1;
        tick();
        bus.Pin = 8'h08;
        tick();
        chk("ok_lat", outs(), ABR);
        repeat (4) tick();
        chk("ok_held", outs(), ABR);
        bus.Pin      = 8'h00;
        bus.Vehiculo = 1'b0;
        bus.Termino  = 1'b1;
        tick();
        chk("pass2", outs(), CER);
        bus.Termino = 1'b0;

        // Wrong code held four cycles counts once.
        bus.Vehiculo = 1'b1;
        tick();
        bus.Pin = 8'hFF;
        repeat (4) tick();
        chk("held_once", outs(), CER);
        bus.Pin = 8'h00;
        tick();
        entry(8'hFF);
        chk("held_cnt2", outs(), CER);
        bus.Pin = 8'hFF;
        tick();
        chk("held_cnt3", outs(), ALR);
        bus.Pin      = 8'h00;
        bus.Vehiculo = 1'b0;
        tick();
        chk("alr_noveh", outs(), ALR);

        // Reset wins over a correct code in the same cycle.
        bus.Pin = 8'h08;
        Reset   = 1'b1;
        tick();
        Reset = 1'b0;
        chk("rst_alr", outs(), CER);
        tick();
        chk("rst_noacc", outs(), CER);
        bus.Pin = 8'h00;
        tick();

        // Counter cleared: two wrongs stay closed, third alarms.
        bus.Vehiculo = 1'b1;
        tick();
        entry(8'h01);
        entry(8'h02);
        chk("cnt_clr", outs(), CER);
        bus.Pin = 8'h03;
        tick();
        chk("cnt_alr", outs(), ALR);
        bus.Pin = 8'h00;
        tick();

        // Tailgating lock.
        bus.Pin = 8'h08;
        tick();
        chk("open3", outs(), ABR);
        bus.Pin     = 8'h00;
        bus.Termino = 1'b1;
        tick();
        chk("lock", outs(), BLQ);
        bus.Termino = 1'b0;
        entry(8'h22);
        chk("lock_bad", outs(), BLQ);
        bus.Pin      = 8'h08;
        bus.Vehiculo = 1'b0;
        tick();
        chk("unlock", outs(), CER);
        bus.Pin = 8'h00;
        tick();

        // Pin event beats Vehiculo falling.
        bus.Vehiculo = 1'b1;
        tick();
        bus.Vehiculo = 1'b0;
        bus.Pin      = 8'h08;
        tick();
        chk("evt_prio", outs(), ABR);
        bus.Pin     = 8'h00;
        bus.Termino = 1'b1;
        tick();
        chk("pass4", outs(), CER);
        bus.Termino = 1'b0;

        // Vehicle leaves without entry; idle ignores codes and Termino.
        bus.Vehiculo = 1'b1;
        tick();
        bus.Vehiculo = 1'b0;
        tick();
        bus.Pin     = 8'h08;
        bus.Termino = 1'b1;
        tick();
        chk("idle_ign", outs(), CER);
        bus.Pin     = 8'h00;
        bus.Termino = 1'b0;
        tick();
        chk("idle_end", outs(), CER);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
